// File: rtl/fill_readout_sequencer_if.sv
// fill_readout_sequencer_if: fill FIFO, channel request/response streams and DAQ link of the readout sequencer.
interface fill_readout_sequencer_if #(parameter int NUM_CHAN = 5);
  logic [NUM_CHAN-1:0] chan_enable;
  logic fill_valid, fill_ready;
  logic [23:0] fill_num;
  logic req_tvalid, req_tready, req_tlast;
  logic [31:0] req_tdata;
  logic rsp_tvalid, rsp_tready, rsp_tlast;
  logic [31:0] rsp_tdata;
  logic daq_valid, daq_header, daq_trailer, daq_ready;
  logic [63:0] daq_data;
  logic busy;
  logic [15:0] timeout_count;
  logic [3:0] last_timeout_chan;
  modport master(
    input chan_enable, fill_valid, fill_num, req_tready, rsp_tvalid, rsp_tdata, rsp_tlast, daq_ready,
    output fill_ready, req_tvalid, req_tdata, req_tlast, rsp_tready, daq_valid, daq_header, daq_trailer,
    daq_data, busy, timeout_count, last_timeout_chan
  );
  modport slave(
    output chan_enable, fill_valid, fill_num, req_tready, rsp_tvalid, rsp_tdata, rsp_tlast, daq_ready,
    input fill_ready, req_tvalid, req_tdata, req_tlast, rsp_tready, daq_valid, daq_header, daq_trailer,
    daq_data, busy, timeout_count, last_timeout_chan
  );
endinterface

// File: rtl/fill_readout_sequencer.sv
// fill_readout_sequencer: per-fill header, channel readout packed 2x32 into DAQ words, trailer, per-channel watchdog.
module fill_readout_sequencer #(
  parameter int NUM_CHAN = 5,
  parameter int TIMEOUT = 1250000
) (
  input logic clk,
  input logic rst,
  fill_readout_sequencer_if.master bus
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, HDR, SCAN, REQ, DATA, TRL} state_t;
  state_t state;
  logic [23:0] f;
  logic [15:0] m;
  logic [19:0] w;
  logic [4:0] ch;
  logic [WDW-1:0] wd;
  logic half, fin;
  assign bus.fill_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.req_tlast = bus.req_tvalid;
  assign bus.rsp_tready = state == DATA && !bus.daq_valid;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      f <= '0;
      m <= '0;
      w <= '0;
      ch <= '0;
      wd <= '0;
      half <= 1'b0;
      fin <= 1'b0;
      bus.req_tvalid <= 1'b0;
      bus.req_tdata <= '0;
      bus.daq_valid <= 1'b0;
      bus.daq_header <= 1'b0;
      bus.daq_trailer <= 1'b0;
      bus.daq_data <= '0;
      bus.timeout_count <= '0;
      bus.last_timeout_chan <= '0;
    end else
      case (state)
        IDLE:
          if (bus.fill_valid) begin
            f <= bus.fill_num;
            m <= 16'(bus.chan_enable);
            w <= '0;
            bus.daq_valid <= 1'b1;
            bus.daq_header <= 1'b1;
            bus.daq_data <= {8'h00, bus.fill_num, 16'h0000, 16'(bus.chan_enable)};
            state <= HDR;
          end
        HDR:
          if (bus.daq_ready) begin
            bus.daq_valid <= 1'b0;
            bus.daq_header <= 1'b0;
            w <= 20'd1;
            ch <= '0;
            state <= SCAN;
          end
        SCAN:
          if (ch == 5'(NUM_CHAN)) begin
            bus.daq_valid <= 1'b1;
            bus.daq_trailer <= 1'b1;
            bus.daq_data <= {8'h00, f, 12'h000, w + 20'd1};
            state <= TRL;
          end else if (m[ch[3:0]]) begin
            bus.req_tvalid <= 1'b1;
            bus.req_tdata <= {4'h1, ch[3:0], f};
            state <= REQ;
          end else
            ch <= ch + 5'd1;
        REQ:
          if (bus.req_tready) begin
            bus.req_tvalid <= 1'b0;
            wd <= '0;
            half <= 1'b0;
            fin <= 1'b0;
            state <= DATA;
          end
        DATA:
          if (bus.daq_valid) begin
            if (bus.daq_ready) begin
              bus.daq_valid <= 1'b0;
              w <= w + 20'd1;
              if (fin) begin
                fin <= 1'b0;
                ch <= ch + 5'd1;
                state <= SCAN;
              end
            end
          end else if (bus.rsp_tvalid) begin
            wd <= '0;
            if (half) begin
              bus.daq_data[31:0] <= bus.rsp_tdata;
              half <= 1'b0;
              bus.daq_valid <= 1'b1;
              fin <= bus.rsp_tlast;
            end else begin
              // lower half pre-zeroed so a lone tlast or timeout flush needs no extra padding step
              bus.daq_data <= {bus.rsp_tdata, 32'h0000_0000};
              half <= !bus.rsp_tlast;
              bus.daq_valid <= bus.rsp_tlast;
              fin <= bus.rsp_tlast;
            end
          end else if (wd == WDW'(TIMEOUT - 1)) begin
            wd <= '0;
            bus.timeout_count <= bus.timeout_count + 16'(bus.timeout_count != 16'hFFFF);
            bus.last_timeout_chan <= ch[3:0];
            half <= 1'b0;
            if (half) begin
              bus.daq_valid <= 1'b1;
              fin <= 1'b1;
            end else begin
              ch <= ch + 5'd1;
              state <= SCAN;
            end
          end else
            wd <= wd + WDW'(1);
        TRL:
          if (bus.daq_ready) begin
            bus.daq_valid <= 1'b0;
            bus.daq_trailer <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_fill_readout_sequencer.sv
// tb_fill_readout_sequencer: randomized fills checked against a queue-based model of the DAQ event stream.
module tb_fill_readout_sequencer;
  localparam int NC = 5;
  localparam int TO = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fill_readout_sequencer_if #(.NUM_CHAN(NC)) bus();
  fill_readout_sequencer #(.NUM_CHAN(NC), .TIMEOUT(TO)) dut(.clk(clk), .rst(rst), .bus(bus.master));
  int n_cmp = 0, n_bad = 0;
  int nw[NC];
  bit dead[NC];
  logic [31:0] words[NC][$];
  logic [65:0] exp_daq[$];
  logic [31:0] exp_req[$];
  int exp_to = 0;
  logic [3:0] exp_last = '0;
  int ready_pct = 70;
  bit abort = 1'b0;
  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask
  task automatic set_chan(input int c, input int n, input bit d);
    nw[c] = n;
    dead[c] = d;
  endtask
  // reference: header, each enabled channel's words paired (odd tail zero-padded), trailer with total word count
  task automatic plan(input logic [NC-1:0] m, input logic [23:0] f);
    int cnt = 2;
    exp_daq.push_back({2'b10, 8'h00, f, 16'h0000, 16'(m)});
    for (int c = 0; c < NC; c++)
      if (m[c]) begin
        exp_req.push_back({4'h1, 4'(c), f});
        words[c] = {};
        for (int i = 0; i < nw[c]; i++) words[c].push_back($urandom);
        for (int i = 0; i < nw[c]; i += 2) begin
          exp_daq.push_back({2'b00, words[c][i], (i + 1 < nw[c]) ? words[c][i+1] : 32'h0});
          cnt++;
        end
        if (dead[c]) begin
          exp_to++;
          exp_last = 4'(c);
        end
      end
    exp_daq.push_back({2'b01, 8'h00, f, 12'h000, 20'(cnt)});
  endtask
  task automatic start_fill(input logic [NC-1:0] m, input logic [23:0] f);
    plan(m, f);
    @(negedge clk);
    check("fill_ready", bus.fill_ready, 1);
    bus.fill_valid = 1'b1;
    bus.fill_num = f;
    bus.chan_enable = m;
    @(negedge clk);
    bus.fill_valid = 1'b0;
  endtask
  task automatic run_fill(input logic [NC-1:0] m, input logic [23:0] f);
    int t = 0;
    start_fill(m, f);
    while ((exp_daq.size() != 0 || bus.busy) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("fill_done", t < 20000, 1);
    check("req_left", exp_req.size(), 0);
    check("to_count", bus.timeout_count, exp_to);
    check("to_chan", bus.last_timeout_chan, exp_last);
    check("fill_ready_after", bus.fill_ready, 1);
  endtask
  task automatic send(input int c);
    int t;
    for (int i = 0; i < words[c].size() && !abort; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      bus.rsp_tvalid = 1'b1;
      bus.rsp_tdata = words[c][i];
      bus.rsp_tlast = !dead[c] && i == words[c].size() - 1;
      while (!bus.rsp_tready && !abort) @(negedge clk);
      @(negedge clk);
      bus.rsp_tvalid = 1'b0;
      bus.rsp_tlast = 1'b0;
    end
    if (dead[c] && words[c].size() % 2 == 1 && !abort) begin
      t = 0;
      while (!bus.daq_valid && t < TO * 4) begin
        @(negedge clk);
        t++;
      end
      check("wd_cycles", t, TO);
    end
  endtask
  initial forever begin
    @(negedge clk);
    bus.req_tready = 1'b0;
    if (bus.req_tvalid && !abort && $urandom_range(0, 1) == 1) begin
      int c;
      bus.req_tready = 1'b1;
      check("req_tlast", bus.req_tlast, 1);
      if (exp_req.size() == 0) check("req_extra", 1, 0);
      else check("req_word", bus.req_tdata, exp_req.pop_front());
      c = int'(bus.req_tdata[27:24]);
      @(negedge clk);
      bus.req_tready = 1'b0;
      if (c < NC) send(c);
    end
  end
  initial forever begin
    @(negedge clk);
    bus.daq_ready = $urandom_range(0, 99) < ready_pct;
    if (bus.daq_valid) begin
      check("rsp_hold", bus.rsp_tready, 0);
      check("hdr_trl", bus.daq_header & bus.daq_trailer, 0);
      if (bus.daq_ready) begin
        if (exp_daq.size() == 0) check("daq_extra", 1, 0);
        else check("daq_word", {bus.daq_header, bus.daq_trailer, bus.daq_data}, exp_daq.pop_front());
      end
    end
  end
  initial begin
    #900000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1);
  end
  initial begin
    int t;
    bus.fill_valid = 1'b0;
    bus.fill_num = '0;
    bus.chan_enable = '0;
    bus.req_tready = 1'b0;
    bus.rsp_tvalid = 1'b0;
    bus.rsp_tdata = '0;
    bus.rsp_tlast = 1'b0;
    bus.daq_ready = 1'b0;
    #1;
    check("rst_daq_valid", bus.daq_valid, 0);
    check("rst_req_tvalid", bus.req_tvalid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_to_count", bus.timeout_count, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("idle_fill_ready", bus.fill_ready, 1);
    set_chan(0, 4, 0);
    run_fill(5'b00001, 24'h000123);
    for (int c = 0; c < NC; c++) set_chan(c, 3, 0);
    run_fill(5'b10101, 24'(($urandom)));
    run_fill(5'b00000, 24'h00abcd);
    set_chan(2, 1, 1);
    run_fill(5'b00100, 24'h000777);
    ready_pct = 33;
    set_chan(1, 64, 0);
    run_fill(5'b00010, 24'h0a0b0c);
    ready_pct = 70;
    repeat (30) begin
      for (int c = 0; c < NC; c++)
        if ($urandom_range(0, 5) == 0) set_chan(c, $urandom_range(0, 4), 1);
        else set_chan(c, $urandom_range(1, 9), 0);
      run_fill(5'($urandom_range(0, 31)), 24'($urandom));
    end
    set_chan(0, 64, 0);
    start_fill(5'b00001, 24'h00beef);
    t = 0;
    while (!bus.rsp_tready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("reach_data", t < 1000, 1);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_daq_valid", bus.daq_valid, 0);
    check("mid_rst_req_tvalid", bus.req_tvalid, 0);
    check("mid_rst_rsp_tready", bus.rsp_tready, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_to_count", bus.timeout_count, 0);
    check("mid_rst_to_chan", bus.last_timeout_chan, 0);
    check("mid_rst_hdr_trl", {bus.daq_header, bus.daq_trailer}, 0);
    exp_daq.delete();
    exp_req.delete();
    exp_to = 0;
    exp_last = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    abort = 1'b0;
    set_chan(0, 2, 0);
    set_chan(3, 5, 0);
    run_fill(5'b01001, 24'h123456);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fill_readout_sequencer.md
Name: fill_readout_sequencer

Overview:
Per-fill readout controller between the fill-number FIFO, the channel serial-link AXI4-Stream pair and the AMC13 DAQ link. For each fill number popped from the FIFO, it emits an event header. It then sends a readout request to each enabled channel FPGA in ascending index order and forwards each channel's response stream, packed 2x32 into 64-bit DAQ words. It closes the event with a trailer. A per-channel watchdog prevents a dead channel from stalling the DAQ.

Parameters:
NUM_CHAN, 5, number of channel FPGAs (1..16)
TIMEOUT, 1250000, clk cycles without a response beat before a channel is abandoned (10 ms at 125 MHz)

Ports:
clk  in  1  system clock (125 MHz domain)
rst  in  1  asynchronous, active-high reset
chan_enable  in  NUM_CHAN  channel enable mask, latched when a fill is accepted
fill_valid  in  1  fill-number FIFO valid
fill_ready  out  1  fill-number FIFO pop
fill_num  in  24  fill number
req_tvalid  out  1  request stream valid (to channel TX FIFO)
req_tready  in  1  request stream ready
req_tdata  out  32  request word
req_tlast  out  1  always 1 with req_tvalid
rsp_tvalid  in  1  response stream valid (from channel RX FIFO)
rsp_tready  out  1  response stream ready
rsp_tdata  in  32  response word
rsp_tlast  in  1  last word of channel response
daq_valid  out  1  DAQ word valid
daq_header  out  1  current DAQ word is header
daq_trailer  out  1  current DAQ word is trailer
daq_data  out  64  DAQ word
daq_ready  in  1  DAQ link ready
busy  out  1  high in any state other than IDLE
timeout_count  out  16  saturating count of abandoned channels
last_timeout_chan  out  4  index of most recently abandoned channel

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs 0. Counters 0. Packing register empty. Any event in progress is abandoned; no trailer is emitted.
- Handshakes:
  - A transfer occurs only on a valid&ready cycle.
  - req_tvalid and daq_valid stay high, with data/flags stable, until accepted.
- fill_ready = (state==IDLE). It is combinational from state only.
- IDLE: on fill_valid (pop), latch fill_num→F and chan_enable→M; clear word count W; go to HDR.
- HDR:
  - Drive daq_data={8'h00, F, 16'h0000, M zero-extended to 16}, daq_header=1.
  - On accept: W=1, ch=0, go to SCAN.
- SCAN (1 cycle per channel index):
  - If ch==NUM_CHAN, go to TRL.
  - Else if M[ch], go to REQ.
  - Else ch++.
- REQ:
  - req_tdata={4'h1, ch[3:0], F}.
  - On accept: clear watchdog, go to DATA.
- DATA:
  - rsp_tready=1 when the packing register is empty or half-full.
  - rsp_tready=0 while a full 64-bit word is pending (daq_valid & !daq_ready).
  - First beat → daq_data[63:32]; second beat → [31:0], then assert daq_valid.
  - On a tlast beat with only the upper half filled: lower half=0, assert daq_valid.
  - Each DAQ accept increments W.
  - After the tlast beat's word is accepted: ch++, go to SCAN.
- Watchdog (DATA only, including time stalled waiting for the first beat):
  - Counts cycles since the last rsp beat; frozen while a DAQ word is pending.
  - On reaching TIMEOUT: flush any half-word (zero-padded), increment timeout_count (saturating at 16'hFFFF), set last_timeout_chan=ch.
  - After the flush completes: ch++, go to SCAN.
  - Later beats from the abandoned channel are not drained.
  - If an rsp beat and expiry coincide, the beat wins and the watchdog clears.
- TRL:
  - Drive daq_data={8'h00, F, 12'h000, (W+1)[19:0]}, daq_trailer=1. The count includes header and trailer.
  - On accept: go to IDLE.
- daq_header and daq_trailer are never both 1. Both are 0 on data words.
- W wraps modulo 2^20.

Test Plan:
1. M=5'b00001, F=24'h000123, ch0 returns 4 words A,B,C,D(tlast) → req 32'h10000123; DAQ: header {8'h00,24'h000123,16'h0,16'h0001}, {A,B}, {C,D}; trailer count 4.
2. M=5'b10101, each channel returns 3 words → requests to ch 0, 2, 4 in order; each channel's last DAQ word has [31:0]=0; trailer count 8.
3. M=0 → header, then trailer count 2; req_tvalid never asserted; fill_ready returns high afterwards.
4. TIMEOUT=100, M=5'b00100, ch2 sends 1 word then goes silent → after 100 idle cycles: {word,32'h0} emitted, timeout_count=1, last_timeout_chan=2; trailer count 3.
5. daq_ready toggled with a 1-in-3 duty during a 64-word response → rsp_tready low while a word is pending; all 32 DAQ words correct; no loss or duplication.
6. rst asserted mid-DATA → all outputs 0 within the same cycle, busy=0; next fill produces a clean header.
